movimentacao_servo: RTL

Sweep sequencer for the servo scanning assembly: drives the 2-bit `posicao` input of `controle_servo` back and forth across positions 01 → 10 → 11 → 10 → 01 → …. At each position it waits a settling time, issues a one-cycle `medir` request to the distance-measurement block, and waits for `fim_medida` or a timeout before stepping. It sits between the top-level control (`ligar`) and both the servo PWM path and the measurement unit.

---
 rtl/movimentacao_servo_if.sv | 40 ++++
 rtl/movimentacao_servo.sv | 135 +++++++++++++
 2 files changed

// File: rtl/movimentacao_servo_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : movimentacao_servo_if                                       |
// | Desc   : Control/measurement handshake between the sweep sequencer,  |
// |          the top-level control, the servo PWM path and the distance  |
// |          measurement unit.                                           |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface movimentacao_servo_if;
  logic       ligar;
  logic       fim_medida;
  logic [1:0] posicao;
  logic       medir;
  logic       sentido;
  logic       erro_medida;
  logic [3:0] db_estado;

  // Controller / environment side
  modport master (
    output ligar,
    output fim_medida,
    input  posicao,
    input  medir,
    input  sentido,
    input  erro_medida,
    input  db_estado
  );

  // Sequencer side
  modport slave (
    input  ligar,
    input  fim_medida,
    output posicao,
    output medir,
    output sentido,
    output erro_medida,
    output db_estado
  );
endinterface
`default_nettype wire

// File: rtl/movimentacao_servo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : movimentacao_servo                                          |
// | Desc   : Servo sweep sequencer. Steps the servo position code        |
// |          01->10->11->10->01..., waits a settling time at each stop,  |
// |          requests one measurement and waits for completion or a      |
// |          timeout before stepping again.                              |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module movimentacao_servo #(
  parameter int DWELL   = 25_000_000,
  parameter int TIMEOUT = 2_500_000
) (
  input  wire logic           clock,
  input  wire logic           reset,
  movimentacao_servo_if.slave bus
);

  localparam int C_MAX   = (DWELL > TIMEOUT) ? DWELL : TIMEOUT;
  localparam int C_CNT_W = (C_MAX > 1) ? $clog2(C_MAX) : 1;
  localparam logic [C_CNT_W-1:0] C_DWELL_LAST   = C_CNT_W'(DWELL - 1);
  localparam logic [C_CNT_W-1:0] C_TIMEOUT_LAST = C_CNT_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    ST_INICIAL   = 4'd0,
    ST_POSICIONA = 4'd1,
    ST_MEDE      = 4'd2,
    ST_AGUARDA   = 4'd3,
    ST_PROXIMO   = 4'd4
  } estado_t;

  estado_t              r_estado;
  logic [1:0]           r_posicao;
  logic                 r_medir;
  logic                 r_sentido;
  logic                 r_erro_medida;
  logic [C_CNT_W-1:0]   r_cnt_dwell;
  logic [C_CNT_W-1:0]   r_cnt_timeout;

  // Sweep FSM: state, position, direction, counters and one-cycle pulses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado      <= ST_INICIAL;
      r_posicao     <= 2'b00;
      r_medir       <= 1'b0;
      r_sentido     <= 1'b1;
      r_erro_medida <= 1'b0;
      r_cnt_dwell   <= '0;
      r_cnt_timeout <= '0;
    end else begin
      // Pulses last one cycle unless re-asserted below
      r_medir       <= 1'b0;
      r_erro_medida <= 1'b0;
      if (!bus.ligar) begin
        // Stop and park; a pending measurement is dropped silently
        r_estado      <= ST_INICIAL;
        r_posicao     <= 2'b00;
        r_sentido     <= 1'b1;
        r_cnt_dwell   <= '0;
        r_cnt_timeout <= '0;
      end else begin
        case (r_estado)
          ST_INICIAL: begin
            r_estado      <= ST_POSICIONA;
            r_posicao     <= 2'b01;
            r_sentido     <= 1'b1;
            r_cnt_dwell   <= '0;
            r_cnt_timeout <= '0;
          end
          ST_POSICIONA: begin
            if (r_cnt_dwell == C_DWELL_LAST) begin
              r_cnt_dwell <= '0;
              r_estado    <= ST_MEDE;
              r_medir     <= 1'b1;
            end else begin
              r_cnt_dwell <= r_cnt_dwell + 1'b1;
            end
          end
          ST_MEDE: begin
            r_estado      <= ST_AGUARDA;
            r_cnt_timeout <= '0;
          end
          ST_AGUARDA: begin
            // Completion has priority over a simultaneous timeout
            if (bus.fim_medida) begin
              r_estado      <= ST_PROXIMO;
              r_cnt_timeout <= '0;
            end else if (r_cnt_timeout == C_TIMEOUT_LAST) begin
              r_estado      <= ST_PROXIMO;
              r_erro_medida <= 1'b1;
              r_cnt_timeout <= '0;
            end else begin
              r_cnt_timeout <= r_cnt_timeout + 1'b1;
            end
          end
          ST_PROXIMO: begin
            // Reverse at the ends so the code never leaves 01..11
            if (r_sentido) begin
              if (r_posicao == 2'b11) begin
                r_posicao <= 2'b10;
                r_sentido <= 1'b0;
              end else begin
                r_posicao <= r_posicao + 2'd1;
              end
            end else begin
              if (r_posicao == 2'b01) begin
                r_posicao <= 2'b10;
                r_sentido <= 1'b1;
              end else begin
                r_posicao <= r_posicao - 2'd1;
              end
            end
            r_cnt_dwell <= '0;
            r_estado    <= ST_POSICIONA;
          end
          default: begin
            r_estado      <= ST_INICIAL;
            r_posicao     <= 2'b00;
            r_sentido     <= 1'b1;
            r_cnt_dwell   <= '0;
            r_cnt_timeout <= '0;
          end
        endcase
      end
    end
  end

  assign bus.posicao     = r_posicao;
  assign bus.medir       = r_medir;
  assign bus.sentido     = r_sentido;
  assign bus.erro_medida = r_erro_medida;
  assign bus.db_estado   = r_estado;

endmodule
`default_nettype wire
